// File: rtl/fetch_pipe_ctrl_if.sv
// fetch_pipe_ctrl_if: hazard-unit controls, imem fetch path and IF/ID feedback bundle
interface fetch_pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             PC_Write;
    logic             IFIDWrite;
    logic             Redirect;
    logic [31:0]      Redirect_Target;
    logic [31:0]      Instr_in;
    logic [31:0]      PC;
    logic [31:0]      PC_IF_ID;
    logic [31:0]      Instr_IF_ID;
    logic             Valid_IF_ID;
    logic [6:0]       Opcode_IF_ID;
    logic [4:0]       RegisterRs1_IF_ID;
    logic [4:0]       RegisterRs2_IF_ID;
    logic [CNT_W-1:0] Stall_Count;
    logic [CNT_W-1:0] Flush_Count;

    modport master (
        output PC_Write, IFIDWrite, Redirect, Redirect_Target, Instr_in,
        input  PC, PC_IF_ID, Instr_IF_ID, Valid_IF_ID, Opcode_IF_ID,
               RegisterRs1_IF_ID, RegisterRs2_IF_ID, Stall_Count, Flush_Count
    );
    modport slave (
        input  PC_Write, IFIDWrite, Redirect, Redirect_Target, Instr_in,
        output PC, PC_IF_ID, Instr_IF_ID, Valid_IF_ID, Opcode_IF_ID,
               RegisterRs1_IF_ID, RegisterRs2_IF_ID, Stall_Count, Flush_Count
    );
endinterface

// File: rtl/fetch_pipe_ctrl.sv
// fetch_pipe_ctrl: PC and IF/ID register with stall/flush handling and event counters
module fetch_pipe_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 16
) (
    input logic              clk,
    input logic              rst,
    fetch_pipe_ctrl_if.slave bus
);
    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;

    logic [1:0]       r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_pc_ifid;
    logic [31:0]      r_instr;
    logic             r_valid;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [31:0]      w_pc_inc;
    logic             w_redir;

    assign w_pc_inc = r_pc + 32'd4;
    // A redirect is only trusted when ID is advancing; a stalled branch has no valid outcome yet
    assign w_redir  = bus.Redirect & bus.IFIDWrite;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_BOOT;
            r_pc        <= RESET_PC;
            r_pc_ifid   <= '0;
            r_instr     <= NOP_INSTR;
            r_valid     <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (r_state == S_BOOT) begin
            r_pc      <= w_pc_inc;
            r_instr   <= bus.Instr_in;
            r_pc_ifid <= r_pc;
            r_valid   <= 1'b1;
            r_state   <= S_RUN;
        end else begin
            if (w_redir) begin
                r_pc      <= {bus.Redirect_Target[31:2], 2'b00};
                r_instr   <= NOP_INSTR;
                r_pc_ifid <= '0;
                r_valid   <= 1'b0;
                if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
            end else begin
                if (bus.PC_Write) r_pc <= w_pc_inc;
                if (bus.IFIDWrite) begin
                    r_instr   <= bus.Instr_in;
                    r_pc_ifid <= r_pc;
                    r_valid   <= 1'b1;
                end
            end
            if (!bus.IFIDWrite && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
            r_state <= bus.IFIDWrite ? S_RUN : S_STALL;
        end
    end

    assign bus.PC                = r_pc;
    assign bus.PC_IF_ID          = r_pc_ifid;
    assign bus.Instr_IF_ID       = r_instr;
    assign bus.Valid_IF_ID       = r_valid;
    assign bus.Opcode_IF_ID      = r_instr[6:0];
    assign bus.RegisterRs1_IF_ID = r_instr[19:15];
    assign bus.RegisterRs2_IF_ID = r_instr[24:20];
    assign bus.Stall_Count       = r_stall_cnt;
    assign bus.Flush_Count       = r_flush_cnt;
endmodule

// File: doc/fetch_pipe_ctrl.md
Name: fetch_pipe_ctrl

Overview:
Fetch-side consumer of the hazard unit's stall/flush controls in the 5-stage RV32I pipeline. It owns the PC register and the IF/ID pipeline register. It applies PC_Write/IFIDWrite stalls and ID-stage branch/jump redirects (flush). It feeds the decoded IF/ID fields (opcode, rs1, rs2) back to the hazard unit and keeps saturating stall/flush event counters.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted into IF/ID on flush
CNT_W, 16, width of the stall and flush event counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
PC_Write  in  1  from hazard unit; 0 = hold PC
IFIDWrite  in  1  from hazard unit; 0 = hold IF/ID
Redirect  in  1  branch taken or JAL/JALR resolved in ID this cycle
Redirect_Target  in  32  target PC for Redirect
Instr_in  in  32  instruction memory read data for the current PC (combinational imem)
PC  out  32  current fetch address to instruction memory
PC_IF_ID  out  32  PC of the instruction held in IF/ID
Instr_IF_ID  out  32  instruction held in IF/ID
Valid_IF_ID  out  1  IF/ID holds a real (non-bubble) instruction
Opcode_IF_ID  out  7  Instr_IF_ID[6:0]
RegisterRs1_IF_ID  out  5  Instr_IF_ID[19:15]
RegisterRs2_IF_ID  out  5  Instr_IF_ID[24:20]
Stall_Count  out  CNT_W  cycles with IFIDWrite=0, saturating
Flush_Count  out  CNT_W  accepted redirects, saturating

Behaviour:
- Reset (async on rst=1, held while high): PC=RESET_PC; PC_IF_ID=0; Instr_IF_ID=NOP_INSTR; Valid_IF_ID=0; counters=0; FSM=BOOT.
- Field outputs are combinational slices of Instr_IF_ID. No extra latency.
- FSM states:
  - BOOT: first edge after reset release. IF/ID loads Instr_in/PC with Valid=1, PC+=4, then go to RUN. Stall and redirect are ignored in this cycle (IF/ID is empty).
  - RUN: normal operation, per the priority table below. Go to STALL when IFIDWrite=0.
  - STALL: IF/ID held. Return to RUN on the first cycle with IFIDWrite=1.
- Per rising edge, in priority order (RUN/STALL):
  1. Redirect=1 and IFIDWrite=1: PC←Redirect_Target; Instr_IF_ID←NOP_INSTR; PC_IF_ID←0; Valid_IF_ID←0; Flush_Count+1. PC_Write is ignored (redirect overrides a PC hold).
  2. Redirect=1 and IFIDWrite=0: redirect is ignored, because the branch in ID is stalled on a load and its outcome is not yet valid. Stall rules apply.
  3. No redirect: PC←PC+4 if PC_Write=1, else hold. IF/ID←{Instr_in, PC, Valid=1} if IFIDWrite=1, else hold all IF/ID fields including Valid.
- PC_Write=1 with IFIDWrite=0 (not produced by the hazard unit) is still defined: PC advances and IF/ID holds. The instruction fetched in that window is lost. The bench checks this but it is not a use case.
- PC+4 wraps modulo 2^32 (32'hFFFF_FFFC → 0). Redirect_Target[1:0] is forced to 00 before loading.
- Stall_Count increments on every edge with IFIDWrite=0 outside BOOT. Flush_Count increments only on accepted redirects. Both saturate at all-ones with no wrap.
- Reset mid-stall or mid-flush: all state returns to reset values immediately and asynchronously. The next edge after release is BOOT.

Test Plan:
- Reset/boot: rst high 3 cycles, then release; Instr_in=32'h00500093 at PC=0 → after 1 edge PC=4, Instr_IF_ID=00500093, Valid=1, Opcode_IF_ID=7'h13, Rs1=0.
- Load-use stall: PC_Write=0, IFIDWrite=0 for 1 cycle at PC=8 → PC stays 8, IF/ID unchanged, Stall_Count=1; next cycle with both=1 → PC=12.
- Taken branch: Redirect=1, Redirect_Target=32'h40, IFIDWrite=1 at PC=0x10 → PC=0x40, Instr_IF_ID=00000013, Valid=0, Flush_Count=1; next edge IF/ID holds Instr_in@0x40 with Valid=1.
- Redirect during stall: Redirect=1, Target=0x80, IFIDWrite=0, PC_Write=0 → PC unchanged, Flush_Count unchanged. Next cycle Redirect=1, IFIDWrite=1 → PC=0x80.
- Wrap/saturation: force PC=32'hFFFF_FFFC → next PC=0. Hold IFIDWrite=0 for 65540 cycles → Stall_Count=16'hFFFF.
- Async reset mid-operation: assert rst between edges while in STALL → PC=RESET_PC, Valid=0 and counters=0 before the next clock edge.
